// File: rtl/nixie_display_arbiter.sv
// Round-robin arbiter sharing one two-digit nixie driver among four requesters,
// with a minimum dwell per grant; drives the driver's Data_Bin/EN directly.
//
// state | meaning
// IDLE  | no grant, EN low, Data_Bin holds the last shown value
// GRANT | Gnt one-hot on Ptr, dwell counter running, EN high
module nixie_display_arbiter #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int CNT_W        = 26
) (
  input  logic        Sys_CLK,
  input  logic        Sys_RST_N,
  input  logic [3:0]  Req,
  input  logic [31:0] Data_In,
  output logic [3:0]  Gnt,
  output logic [7:0]  Data_Bin,
  output logic        EN
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       gnt_nxt;
  logic [7:0]       data_nxt;
  logic             en_nxt;

  logic [1:0] p1, p2, p3, win;
  logic       any_req;
  logic [4:0] win_base, ptr_base;

  // Winner scan starts just after the last owner, so the owner itself is last.
  assign p1       = ptr + 2'd1;
  assign p2       = ptr + 2'd2;
  assign p3       = ptr + 2'd3;
  assign any_req  = |Req;
  assign win      = Req[p1] ? p1 : Req[p2] ? p2 : Req[p3] ? p3 : ptr;
  assign win_base = {win, 3'b000};
  assign ptr_base = {ptr, 3'b000};

  always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
    if (!Sys_RST_N) begin
      state    <= IDLE;
      ptr      <= 2'd3;
      cnt      <= '0;
      Gnt      <= 4'b0000;
      Data_Bin <= 8'h00;
      EN       <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      Gnt      <= gnt_nxt;
      Data_Bin <= data_nxt;
      EN       <= en_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = Gnt;
    data_nxt  = Data_Bin;
    en_nxt    = EN;

    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = GRANT;
          ptr_nxt   = win;
          cnt_nxt   = '0;
          gnt_nxt   = 4'b0001 << win;
          data_nxt  = Data_In[win_base +: 8];
          en_nxt    = 1'b1;
        end
      end
      GRANT: begin
        // Release outranks dwell expiry when both happen on the same edge.
        if (!Req[ptr] || cnt == CNT_LAST) begin
          if (any_req) begin
            ptr_nxt  = win;
            cnt_nxt  = '0;
            gnt_nxt  = 4'b0001 << win;
            data_nxt = Data_In[win_base +: 8];
            en_nxt   = 1'b1;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            gnt_nxt   = 4'b0000;
            en_nxt    = 1'b0;
          end
        end else begin
          cnt_nxt  = cnt + CNT_W'(1);
          data_nxt = Data_In[ptr_base +: 8];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nixie_display_arbiter.sv
// Directed bench for nixie_display_arbiter with a short dwell of 4 cycles.
module tb_nixie_display_arbiter;

  logic        clk_sys;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  gnt;
  logic [7:0]  data_bin;
  logic        en;

  int n_tests = 0;
  int n_fail  = 0;

  nixie_display_arbiter #(.DWELL_CYCLES(4), .CNT_W(3)) dut (
    .Sys_CLK   (clk_sys),
    .Sys_RST_N (rst_n),
    .Req       (req),
    .Data_In   (data_in),
    .Gnt       (gnt),
    .Data_Bin  (data_bin),
    .EN        (en)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [7:0] d, input logic e);
    check_val({tag, ".gnt"}, {28'd0, gnt}, {28'd0, g});
    check_val({tag, ".data"}, {24'd0, data_bin}, {24'd0, d});
    check_val({tag, ".en"}, {31'd0, en}, {31'd0, e});
  endtask

  logic [3:0] exp_g;
  logic [7:0] exp_d;

  initial begin
    rst_n   = 1'b1;
    req     = 4'b0000;
    data_in = 32'h0;
    #2 rst_n = 1'b0;
    #1 check_out("reset", 4'b0000, 8'h00, 1'b0);
    #20 rst_n = 1'b1;
    step();
    check_out("idle_after_reset", 4'b0000, 8'h00, 1'b0);

    // Single requester: grant after one edge, then steady across dwell expiries.
    req     = 4'b0001;
    data_in = 32'h0000003A;
    step();
    check_out("single_grant", 4'b0001, 8'h3A, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      check_out("single_hold", 4'b0001, 8'h3A, 1'b1);
    end

    req = 4'b0000;
    step();
    check_out("single_drop", 4'b0000, 8'h3A, 1'b0);

    // All four requesting: rotation starts after last owner (0), 4 cycles each.
    req     = 4'b1111;
    data_in = 32'h44332211;
    for (int k = 0; k < 16; k++) begin
      step();
      exp_g = 4'b0001 << ((1 + k / 4) % 4);
      exp_d = 8'h11 * (8'((1 + k / 4) % 4) + 8'd1);
      check_out("rotate", exp_g, exp_d, 1'b1);
    end
    step();
    check_out("rotate_wrap", 4'b0010, 8'h22, 1'b1);

    // Owner 1 releases mid-dwell with 0 and 2 waiting: index 2 comes first.
    step();
    req = 4'b0101;
    step();
    check_out("release_switch", 4'b0100, 8'h33, 1'b1);
    req = 4'b0000;
    step();
    check_out("release_idle", 4'b0000, 8'h33, 1'b0);

    // Owner live value update appears one cycle later.
    req     = 4'b0001;
    data_in = 32'h00000005;
    step();
    check_out("live_grant", 4'b0001, 8'h05, 1'b1);
    data_in = 32'h00000006;
    step();
    check_out("live_update", 4'b0001, 8'h06, 1'b1);

    // Release on the expiry cycle: goes idle, no regrant of the old owner.
    step();
    step();
    check_out("pre_expiry", 4'b0001, 8'h06, 1'b1);
    req = 4'b0000;
    step();
    check_out("release_on_expiry", 4'b0000, 8'h06, 1'b0);
    step();
    check_out("stay_idle", 4'b0000, 8'h06, 1'b0);

    // Async reset mid-dwell, then requester 3 wins first from Ptr=3.
    req     = 4'b1000;
    data_in = 32'hC7000000;
    step();
    check_out("grant3", 4'b1000, 8'hC7, 1'b1);
    step();
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", 4'b0000, 8'h00, 1'b0);
    #2 rst_n = 1'b1;
    step();
    check_out("after_reset_grant", 4'b1000, 8'hC7, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nixie_display_arbiter.md
Name: nixie_display_arbiter

Overview:
- Shares the two-digit LED nixie display driver among four requesters, e.g. counter value, score, status code and error code.
- Each requester presents an 8-bit value: two hex digits.
- The block grants the display round-robin, with a minimum dwell time per grant.
- It drives the display driver's Data_Bin and EN inputs directly.

Parameters:
- DWELL_CYCLES, 50000000: grant dwell length in Sys_CLK cycles (1 s at 50 MHz); must be >= 1.
- CNT_W, 26: dwell counter width; must satisfy 2^CNT_W >= DWELL_CYCLES.

Ports:
- Sys_CLK  input  1  system clock; all state updates on its rising edge.
- Sys_RST_N  input  1  asynchronous, active-low reset.
- Req  input  4  request lines; Req[i] high means requester i wants the display.
- Data_In  input  32  packed requester values; requester i occupies bits [8i+7:8i].
- Gnt  output  4  one-hot grant, all zero when idle; registered.
- Data_Bin  output  8  value forwarded to the display driver; registered.
- EN  output  1  display enable to the display driver; high while a grant is active; registered.

Behaviour:
- Reset:
  - Sys_RST_N low asynchronously forces state IDLE, Gnt=4'b0000, Data_Bin=8'h00, EN=0, Cnt=0, Ptr=3.
  - Ptr=3 gives requester 0 first priority after reset.
  - Reset asserted mid-grant takes effect immediately, with no drain.
- Round-robin winner W (combinational):
  - Scan indices Ptr+1, Ptr+2, Ptr+3, Ptr (mod 4) in that order; W is the first index with Req high.
  - "Any" means Req != 0.
  - Ptr is the index of the current or most recent grant.
- State IDLE:
  - Outputs: EN=0, Gnt=0; Data_Bin holds its last value.
  - If any Req: next cycle state GRANT, Gnt=onehot(W), Ptr=W, Data_Bin=Data_In[W], EN=1, Cnt=0.
  - Request-to-grant latency is 1 cycle.
- State GRANT: rules are evaluated in priority order each cycle.
  1. Release: Req[Ptr]=0.
     - If any Req: regrant W in the same edge; Cnt=0, Data_Bin=Data_In[W].
     - Otherwise go to IDLE: Gnt=0, EN=0, Data_Bin held.
  2. Dwell expiry: Cnt == DWELL_CYCLES-1.
     - Cnt=0 and regrant W.
     - If another requester is active, W differs from Ptr (fair switch).
     - If only Ptr is requesting, W=Ptr: the grant continues, Gnt is unchanged and no glitch appears.
  3. Otherwise: Cnt=Cnt+1; grant unchanged.
  - In every GRANT cycle that remains granted, Data_Bin=Data_In[new Ptr], registered one cycle. Live value changes from the owner therefore appear with 1-cycle latency.
- Invariants:
  - Gnt is always one-hot or zero.
  - EN=1 exactly when Gnt != 0.
  - A non-owner requester waits at most 3 dwell periods (plus releases) for its grant.
- Simultaneous events:
  - Release and expiry in the same cycle: release rule applies.
  - Request changes during a switch edge: sampled values on that edge decide W.
- DWELL_CYCLES=1: every GRANT cycle is an expiry cycle, so the grant rotates every cycle among the active requesters.
- The counter never exceeds DWELL_CYCLES-1; no wrap-around beyond the parameter.

Test Plan:
- Reset then Req=0001, Data_In[7:0]=8'h3A -> 1 cycle later Gnt=0001, EN=1, Data_Bin=8'h3A; holds steady indefinitely; Cnt restarts every DWELL_CYCLES with no Gnt glitch.
- DWELL_CYCLES=4, Req=1111 constant, Data_In=32'h44332211 -> Gnt sequence 0001,0010,0100,1000,0001..., each held exactly 4 cycles; Data_Bin 11,22,33,44 following Gnt by 0 cycles.
- DWELL_CYCLES=4, Gnt=0010, drop Req[1] at cycle 2 of dwell with Req=0101 -> next edge Gnt=0100 (index 2 before 0), Cnt=0; then drop all Req -> next edge Gnt=0000, EN=0, Data_Bin holds 8'h33.
- Owner live update: Gnt=0001, change Data_In[7:0] 8'h05->8'h06 -> Data_Bin=8'h06 one cycle later, grant unchanged.
- Assert Sys_RST_N low asynchronously mid-dwell (between clock edges) -> Gnt=0, EN=0, Data_Bin=8'h00 immediately; after release with Req=1000 -> Gnt=1000 after 1 cycle.
- Release coinciding with expiry (DWELL_CYCLES=4, drop Req[Ptr] on Cnt=3, Req others=0) -> IDLE, EN=0; the release rule wins, with no spurious regrant of the old owner.
